// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the W x W shift-add sequential multiplier.
package seq_mul_pkg;

    localparam int unsigned MAXW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when a CW-bit counter can reach W without wrapping.
    function automatic bit cw_ok(input int unsigned w, input int unsigned cw);
        return (cw < 32) && ((64'd1 << cw) > 64'(w));
    endfunction

    // Magnitude of a sign-extended operand; raw value when unsigned.
    function automatic logic [MAXW-1:0] abs_w(input logic [MAXW-1:0] x, input logic sgn);
        return (sgn && x[MAXW-1]) ? (~x + MAXW'(1)) : x;
    endfunction

endpackage

// File: rtl/seq_mul_w_if.sv
// Request/result bundle between a MAC/filter controller and seq_mul_w.
interface seq_mul_w_if #(
    parameter int unsigned W = 8
);
    logic           start;
    logic           sgn;
    logic           acc;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [2*W-1:0] O;
    logic           busy;
    logic           fin;

    modport master (output start, sgn, acc, A, B, input O, busy, fin);
    modport slave  (input start, sgn, acc, A, B, output O, busy, fin);
endinterface

// File: rtl/seq_mul_w.sv
// W x W MSB-first shift-add multiplier with signed/unsigned mode and
// optional accumulate into the held result; W iterations per operation.
module seq_mul_w
    import seq_mul_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 6
) (
    input  logic       ck,
    input  logic       rst_n,
    seq_mul_w_if.slave bus
);

    localparam int unsigned PW = 2 * W;

    if (W < 2 || W > MAXW || !cw_ok(W, CW)) begin : g_param_check
        $error("seq_mul_w: illegal W/CW combination");
    end

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [PW-1:0]   p_q, p_d;
    logic [PW-1:0]   o_q, o_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            acc_q, acc_d;
    logic            busy_q, busy_d;
    logic            fin_q, fin_d;

    logic            accept_c;
    logic            last_c;
    logic [PW-1:0]   p_step_c;
    logic [PW-1:0]   r_c;

    assign accept_c = bus.start && (state_q != RUN);
    assign last_c   = (state_q == RUN) && (cnt_q == CW'(W - 1));

    // b_q is shifted left each iteration, so its MSB is bit W-1-k of |B|.
    assign p_step_c = {p_q[PW-2:0], 1'b0} + (b_q[W-1] ? PW'(a_q) : '0);
    assign r_c      = neg_q ? (~p_step_c + PW'(1)) : p_step_c;

    // State register.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE accepts a new start for back-to-back ops.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept_c) state_d = RUN;
            RUN:     if (last_c)   state_d = DONE;
            DONE:    state_d = accept_c ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        o_d    = o_q;
        cnt_d  = cnt_q;
        neg_d  = neg_q;
        acc_d  = acc_q;
        busy_d = (state_d == RUN);
        fin_d  = (state_d == DONE);

        if (accept_c) begin
            a_d   = W'(abs_w(MAXW'($signed(bus.A)), bus.sgn));
            b_d   = W'(abs_w(MAXW'($signed(bus.B)), bus.sgn));
            neg_d = bus.sgn & (bus.A[W-1] ^ bus.B[W-1]);
            acc_d = bus.acc;
            p_d   = '0;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            p_d   = p_step_c;
            b_d   = b_q << 1;
            cnt_d = cnt_q + CW'(1);
            if (last_c) begin
                o_d = r_c + (acc_q ? o_q : '0);
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            o_q    <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            acc_q  <= 1'b0;
            busy_q <= 1'b0;
            fin_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            p_q    <= p_d;
            o_q    <= o_d;
            cnt_q  <= cnt_d;
            neg_q  <= neg_d;
            acc_q  <= acc_d;
            busy_q <= busy_d;
            fin_q  <= fin_d;
        end
    end

    assign bus.O    = o_q;
    assign bus.busy = busy_q;
    assign bus.fin  = fin_q;

endmodule

// File: tb/tb_seq_mul_w.sv
// Self-checking bench for seq_mul_w: directed W=8 cases plus random ops
// at W = 8, 2, 16, 32 against an integer-arithmetic reference model.
module tb_seq_mul_w;

    localparam int NI = 4;
    localparam int unsigned WS [NI] = '{8, 2, 16, 32};

    logic            ck = 1'b0;
    logic            rst_n;
    logic [NI-1:0]   start_v;
    logic            sgn_v;
    logic            acc_v;
    logic [31:0]     a_v;
    logic [31:0]     b_v;
    logic [63:0]     o_mon [NI];
    logic [NI-1:0]   busy_mon;
    logic [NI-1:0]   fin_mon;
    logic [63:0]     o_m   [NI];
    int              n_tests;
    int              n_fail;

    always #5 ck = ~ck;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int unsigned GW = WS[gi];
        seq_mul_w_if #(.W(GW)) bus ();
        assign bus.start    = start_v[gi];
        assign bus.sgn      = sgn_v;
        assign bus.acc      = acc_v;
        assign bus.A        = a_v[GW-1:0];
        assign bus.B        = b_v[GW-1:0];
        assign o_mon[gi]    = 64'(bus.O);
        assign busy_mon[gi] = bus.busy;
        assign fin_mon[gi]  = bus.fin;
        seq_mul_w #(.W(GW), .CW(6)) dut (.ck(ck), .rst_n(rst_n), .bus(bus));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask2(input int unsigned w);
        return (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Operand value as a 64-bit two's-complement integer.
    function automatic logic [63:0] sval(input logic [31:0] x, input bit s, input int unsigned w);
        logic [63:0] v;
        v = 64'(x) & ((64'd1 << w) - 64'd1);
        if (s && x[w-1]) v = v - (64'd1 << w);
        return v;
    endfunction

    function automatic logic [63:0] model(input int s, input logic [31:0] a, input logic [31:0] b,
                                          input bit sg, input bit ac);
        int unsigned w;
        w = WS[s];
        return (sval(a, sg, w) * sval(b, sg, w) + (ac ? o_m[s] : 64'd0)) & mask2(w);
    endfunction

    // Issue one op on instance s from #1 after an edge in IDLE/DONE; ends #1 after the fin edge.
    task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b,
                          input bit sg, input bit ac, input string tag);
        int unsigned w;
        logic [63:0] exp;
        int          lat;
        bit          hold_ok;
        w   = WS[s];
        exp = model(s, a, b, sg, ac);
        a_v = a; b_v = b; sgn_v = sg; acc_v = ac; start_v[s] = 1'b1;
        @(posedge ck); #1;
        start_v[s] = 1'b0;
        a_v = $urandom; b_v = $urandom; sgn_v = 1'($urandom); acc_v = 1'($urandom);
        check({tag, " busy"}, 64'(busy_mon[s]), 64'd1);
        lat = 0;
        hold_ok = 1'b1;
        while (lat < int'(w) + 4) begin
            if (o_mon[s] !== o_m[s] || !busy_mon[s]) hold_ok = 1'b0;
            @(posedge ck); #1;
            lat++;
            if (fin_mon[s]) break;
        end
        check({tag, " latency"}, 64'(lat), 64'(w));
        check({tag, " O"}, o_mon[s], exp);
        check({tag, " busy clr"}, 64'(busy_mon[s]), 64'd0);
        check({tag, " hold/busy in RUN"}, 64'(hold_ok), 64'd1);
        o_m[s] = exp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no summary expected summary");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        bit          rsg, rac;
        bit          seen;
        int          lat;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start_v = '0;
        sgn_v = 1'b0; acc_v = 1'b0; a_v = '0; b_v = '0;
        for (int i = 0; i < NI; i++) o_m[i] = 64'd0;

        #12;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset O[%0d]", i), o_mon[i], 64'd0);
            check($sformatf("reset busy/fin[%0d]", i), 64'({busy_mon[i], fin_mon[i]}), 64'd0);
        end
        @(negedge ck) rst_n = 1'b1;
        @(posedge ck); #1;

        // Unsigned basic op, result held afterwards.
        run_op(0, 13, 11, 1'b0, 1'b0, "t1");
        check("t1 const", o_mon[0], 64'h008F);
        @(posedge ck); #1;
        check("t1 fin drop", 64'(fin_mon[0]), 64'd0);
        repeat (3) @(posedge ck);
        #1;
        check("t1 hold", o_mon[0], 64'd143);

        // Signed cases including the most-negative square and -0.
        run_op(0, 32'hFD, 32'h05, 1'b1, 1'b0, "t2a");
        check("t2a const", o_mon[0], 64'hFFF1);
        run_op(0, 32'h80, 32'h80, 1'b1, 1'b0, "t2b");
        check("t2b const", o_mon[0], 64'h4000);
        run_op(0, 32'h00, 32'hFF, 1'b1, 1'b0, "t2c");
        check("t2c const", o_mon[0], 64'h0000);

        // Unsigned accumulate chain with wrap.
        run_op(0, 255, 255, 1'b0, 1'b0, "t3a");
        check("t3a const", o_mon[0], 64'hFE01);
        run_op(0, 1, 1, 1'b0, 1'b1, "t3b");
        check("t3b const", o_mon[0], 64'hFE02);
        run_op(0, 255, 2, 1'b0, 1'b1, "t3c");
        check("t3c const", o_mon[0], 64'h0000);

        // Starts during RUN are ignored; a start on the DONE cycle is accepted.
        a_v = 10; b_v = 10; sgn_v = 1'b0; acc_v = 1'b0; start_v[0] = 1'b1;
        @(posedge ck); #1;
        a_v = 3; b_v = 4;
        for (int k = 1; k <= 8; k++) begin
            start_v[0] = (k == 2 || k == 5);
            @(posedge ck); #1;
        end
        start_v[0] = 1'b0;
        check("t4 fin", 64'(fin_mon[0]), 64'd1);
        check("t4 O", o_mon[0], 64'd100);
        a_v = 3; b_v = 4; acc_v = 1'b1; start_v[0] = 1'b1;
        @(posedge ck); #1;
        start_v[0] = 1'b0;
        check("t4 b2b fin/busy", 64'({fin_mon[0], busy_mon[0]}), 64'b01);
        check("t4 b2b O held", o_mon[0], 64'd100);
        lat = 0;
        while (lat < 12) begin
            @(posedge ck); #1;
            lat++;
            if (fin_mon[0]) break;
        end
        check("t4 b2b latency", 64'(lat), 64'd8);
        check("t4 b2b O", o_mon[0], 64'd112);
        o_m[0] = 64'd112;

        // Asynchronous reset mid-RUN aborts the op.
        a_v = 50; b_v = 3; sgn_v = 1'b0; acc_v = 1'b0; start_v[0] = 1'b1;
        @(posedge ck); #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge ck);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5 rst O", o_mon[0], 64'd0);
        check("t5 rst busy/fin", 64'({busy_mon[0], fin_mon[0]}), 64'd0);
        for (int i = 0; i < NI; i++) o_m[i] = 64'd0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge ck); #1;
            if (fin_mon[0]) seen = 1'b1;
        end
        @(negedge ck) rst_n = 1'b1;
        repeat (6) begin
            @(posedge ck); #1;
            if (fin_mon[0]) seen = 1'b1;
        end
        check("t5 no fin", 64'(seen), 64'd0);
        run_op(0, 7, 6, 1'b0, 1'b0, "t5 after");
        check("t5 const", o_mon[0], 64'd42);

        // Random signed/unsigned ops and acc chains at every width.
        for (int s = 0; s < NI; s++) begin
            for (int n = 0; n < 20; n++) begin
                ra  = $urandom;
                rb  = $urandom;
                rsg = 1'($urandom);
                rac = 1'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    ra  = 32'd1 << (WS[s] - 1);
                    rb  = ra;
                    rsg = 1'b1;
                end else if ($urandom_range(0, 7) == 0) begin
                    ra  = 32'd0;
                    rsg = 1'b1;
                end
                repeat ($urandom_range(0, 2)) begin
                    @(posedge ck); #1;
                end
                run_op(s, ra, rb, rsg, rac, $sformatf("rnd W%0d #%0d", WS[s], n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
